// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex digit scanner feeding a 4-bit to 7-segment decoder.
// Cycles through NUM_DIGITS digit slots of REFRESH_DIV cycles each. New data
// is only committed at frame boundaries, so a frame never mixes two values.
// Every slot starts with DEAD_CYCLES of all anodes off to prevent ghosting.
// Optional leading-zero blanking keeps the slot timing, so brightness stays constant.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              bin,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [VW-1:0]         r_active_val;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic [VW-1:0]         r_pend_val;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_flag;
    logic                  r_frame_start;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_zero_above;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_shown;

    assign w_slot_end  = (r_cnt == CNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

    // Refresh counter, digit index and frame-start pulse; both counters wrap by compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                if (r_idx == IDX_MAX) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_frame_start <= w_frame_end;
        end
    end

    // Pending capture on load; active data changes only at a frame end (a same-cycle load bypasses pending).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_flag       <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end else begin
                r_pend_val <= r_pend_val;
                r_pend_dp  <= r_pend_dp;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_active_val <= value;
                    r_active_dp  <= dp_in;
                end else if (r_flag) begin
                    r_active_val <= r_pend_val;
                    r_active_dp  <= r_pend_dp;
                end else begin
                    r_active_val <= r_active_val;
                    r_active_dp  <= r_active_dp;
                end
                r_flag <= 1'b0;
            end else if (load) begin
                r_flag <= 1'b1;
            end else begin
                r_flag <= r_flag;
            end
        end
    end

    // Leading-zero blanking: digit i>0 is blanked when it and every higher nibble are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_active_val[4*i +: 4] == 4'd0);
            w_blank[i]   = blank_lz && w_zero_above;
        end
    end

    assign w_shown = (r_cnt >= CNT_DEAD) && !w_blank[r_idx];

    // Output decode straight from registers: nibble, single active-low anode, active-low dp.
    always_comb begin
        an  = '1;
        bin = r_active_val[{r_idx, 2'b00} +: 4];
        if (w_shown) begin
            an[r_idx] = 1'b0;
            dp        = ~r_active_dp[r_idx];
        end else begin
            dp        = 1'b1;
        end
    end

    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with 4 digits, 4-cycle slots and 1 dead cycle.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  bin;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .bin        (bin),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start)
    );

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        blz;
        logic [3:0]  an;
        logic [3:0]  bin;
        logic        dp;
        logic        fs;
    } vec_t;

    vec_t vec [0:127];
    int   nvec;
    logic cur_blz;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int step, input logic [3:0] act, input logic [3:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endtask

    // One digit slot: a dead cycle followed by three lit (or blanked) cycles.
    task automatic push_slot(input logic [3:0] an_e, input logic [3:0] bin_e, input logic dp_lit, input logic fs_e);
        for (int c = 0; c < 4; c++) begin
            vec[nvec].ld  = 1'b0;
            vec[nvec].val = 16'h0000;
            vec[nvec].dpi = 4'b0000;
            vec[nvec].blz = cur_blz;
            vec[nvec].an  = (c == 0) ? 4'b1111 : an_e;
            vec[nvec].bin = bin_e;
            vec[nvec].dp  = (c != 0 && dp_lit && an_e != 4'b1111) ? 1'b0 : 1'b1;
            vec[nvec].fs  = (c == 0) ? fs_e : 1'b0;
            nvec = nvec + 1;
        end
    endtask

    task automatic set_load(input int k, input logic [15:0] v, input logic [3:0] d);
        vec[k].ld  = 1'b1;
        vec[k].val = v;
        vec[k].dpi = d;
    endtask

    task automatic run_vectors(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load     = vec[i].ld;
            value    = vec[i].val;
            dp_in    = vec[i].dpi;
            blank_lz = vec[i].blz;
            #1;
            check("an", i, an, vec[i].an);
            check("bin", i, bin, vec[i].bin);
            check("dp", i, {3'b000, dp}, {3'b000, vec[i].dp});
            check("frame_start", i, {3'b000, frame_start}, {3'b000, vec[i].fs});
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nvec     = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b1;
        #2;
        check("rst_an", -1, an, 4'b1111);
        check("rst_bin", -1, bin, 4'h0);
        check("rst_dp", -1, {3'b000, dp}, 4'b0001);
        check("rst_fs", -1, {3'b000, frame_start}, 4'b0000);

        // Frame A (after reset, blank_lz=1): only digit 0 lit; 12AF loaded mid-frame.
        cur_blz = 1'b1;
        push_slot(4'b1110, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        set_load(5, 16'h12AF, 4'b0100);
        // Frame B: 12AF, dp on digit 2; 0030 loaded.
        cur_blz = 1'b0;
        push_slot(4'b1110, 4'hF, 1'b0, 1'b1);
        push_slot(4'b1101, 4'hA, 1'b0, 1'b0);
        push_slot(4'b1011, 4'h2, 1'b1, 1'b0);
        push_slot(4'b0111, 4'h1, 1'b0, 1'b0);
        set_load(20, 16'h0030, 4'b0000);
        // Frame C (blank_lz=1): 0030 with digits 2,3 blanked; 0000 loaded.
        cur_blz = 1'b1;
        push_slot(4'b1110, 4'h0, 1'b0, 1'b1);
        push_slot(4'b1101, 4'h3, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        set_load(36, 16'h0000, 4'b0000);
        // Frame D: 0000 shows a single 0; 1111 then 2222 loaded.
        push_slot(4'b1110, 4'h0, 1'b0, 1'b1);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0);
        set_load(50, 16'h1111, 4'b0000);
        set_load(56, 16'h2222, 4'b0000);
        // Frame E: last load wins; BEEF loaded on the frame-end cycle.
        cur_blz = 1'b0;
        push_slot(4'b1110, 4'h2, 1'b0, 1'b1);
        push_slot(4'b1101, 4'h2, 1'b0, 1'b0);
        push_slot(4'b1011, 4'h2, 1'b0, 1'b0);
        push_slot(4'b0111, 4'h2, 1'b0, 1'b0);
        set_load(79, 16'hBEEF, 4'b0001);
        // Frame F: BEEF with no extra delay, dp on digit 0.
        push_slot(4'b1110, 4'hF, 1'b1, 1'b1);
        push_slot(4'b1101, 4'hE, 1'b0, 1'b0);
        push_slot(4'b1011, 4'hE, 1'b0, 1'b0);
        push_slot(4'b0111, 4'hB, 1'b0, 1'b0);
        // Frame G: unchanged without a load; 5555 left pending in digit 2 slot.
        push_slot(4'b1110, 4'hF, 1'b1, 1'b1);
        push_slot(4'b1101, 4'hE, 1'b0, 1'b0);
        push_slot(4'b1011, 4'hE, 1'b0, 1'b0);
        set_load(105, 16'h5555, 4'b1111);

        @(posedge clk);
        #1 rst_n = 1'b1;
        run_vectors(106);

        // Digit 2 still shown, then asynchronous reset mid-slot.
        @(negedge clk);
        load = 1'b0;
        #1;
        check("pre_rst_an", 106, an, 4'b1011);
        check("pre_rst_bin", 106, bin, 4'hE);
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 106, an, 4'b1111);
        check("async_rst_bin", 106, bin, 4'h0);
        check("async_rst_dp", 106, {3'b000, dp}, 4'b0001);
        check("async_rst_fs", 106, {3'b000, frame_start}, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // After reset: 0000 with all digits lit; the pending 5555 must not appear.
        nvec    = 0;
        cur_blz = 1'b0;
        push_slot(4'b1110, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1101, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1011, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0111, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1110, 4'h0, 1'b0, 1'b1);
        run_vectors(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scanner directly upstream of the 4-bit-to-7-segment decoder.
- Holds a multi-digit hex value and cycles through the digits at a refresh rate.
- Each slot it presents one nibble on bin (to the decoder) and drives the matching active-low anode.
- Includes tear-free frame-boundary value update, anti-ghosting dead time and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; value width = 4*NUM_DIGITS.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe: capture value/dp_in as pending display data.
- value  in  4*NUM_DIGITS  hex value; nibble i (bits 4i+3:4i) shown on digit i; digit 0 is rightmost/least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- bin  out  4  nibble for the current digit; feeds the decoder's bin input.
- an  out  NUM_DIGITS  anode enables, active-low, at most one bit low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
State and counters:
- Registers: refresh counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), active value/dp, pending value/dp, pending flag.
- Reset (async, rst_n low): cnt=0, idx=0, active=0, pending=0, flag=0.
- Outputs during and immediately after reset: an=all 1, bin=0, dp=1, frame_start=0.
- cnt increments every cycle and wraps REFRESH_DIV-1 -> 0.
- At that wrap ("slot end"), idx advances; NUM_DIGITS-1 -> 0 is the "frame end".

Load and commit:
- load: pending <= value, dp_in; flag <= 1. A later load before commit overwrites pending (last wins).
- Frame end with flag=1: active <= pending, flag <= 0.
- load on the same cycle as frame end: active <= value/dp_in directly, flag <= 0 (new data bypasses pending).
- Frame end with flag=0: active unchanged.
- Active data never changes mid-frame.

Frame start:
- frame_start is a registered output. It is 1 for exactly the one cycle in which idx==0 and cnt==0 following a frame end.
- It is not asserted for the post-reset cycle.

Output decoding (combinational from registers, no further latency):
- bin = active nibble[idx].
- dp = ~active_dp[idx] when the digit is shown, else 1.
- an[idx] = 0 only when cnt >= DEAD_CYCLES and digit idx is not blanked; all other an bits are 1.
- Dead time: all anodes off for cnt < DEAD_CYCLES in every slot, including the first slot after reset.

Blanking:
- Digit i (i > 0) is blanked when blank_lz=1 and active nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked, so value 0 shows a single "0".
- A blanked digit still consumes its full time slot (constant brightness).
- blank_lz is sampled live, not latched.

Timing and errors:
- Scan timing: digit period = REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles.
- Reset mid-frame: immediate return to reset state; pending data and flag are lost.
- No illegal states: idx and cnt wrap by compare, not by width.

Test Plan:
- Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
- Reset release, no load -> an=1111 at cnt=0. Then an=1110 with bin=0 for cnt 1..3, followed by digits 1..3 each with an=1111 (blank_lz=1) or 1101/1011/0111 with bin=0 (blank_lz=0).
- Load value=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged until frame_start. Next frame shows bin F,A,2,1 with an 1110,1101,1011,0111. dp=0 only in the digit-2 slot; each slot has a 1-cycle all-off gap.
- blank_lz=1, load 16'h0030 -> digit 0 shows 0, digit 1 shows 3, digits 2 and 3 keep an=1111 for their whole slots. Load 16'h0000 -> only digit 0 lit with bin=0.
- Load 16'h1111 then 16'h2222 within one frame -> next frame shows 2222 only; 1111 never appears.
- Load 16'hBEEF asserted on the exact frame-end cycle -> the following frame shows BEEF with no extra frame delay.
- Assert rst_n=0 during digit 2 with a pending load -> an=1111, bin=0, dp=1 immediately (asynchronously). After release, the scan restarts at digit 0 showing 0000 and the pending value is discarded.
